// File: rtl/menu_text_reader_if.sv
// Bus bundle between the menu text reader and its host: line request, text RAM,
// font ROM and pixel stream.
interface menu_text_reader_if;
  localparam int unsigned LINE_W = 8;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CHAR_W = 7;
  localparam int unsigned PIX_W  = 8;

  logic              start;
  logic [LINE_W-1:0] line;
  logic              abort;
  logic              hl_en;
  logic [ROW_W-1:0]  hl_row;
  logic              ram_ce;
  logic [ADDR_W-1:0] ram_addr;
  logic [CHAR_W-1:0] ram_dout;
  logic              font_ce;
  logic [ADDR_W-1:0] font_addr;
  logic [PIX_W-1:0]  font_dout;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_last;
  logic              busy;
  logic              done;

  // Host side: issues requests, returns memory data, sinks pixels.
  modport master (
    output start, line, abort, hl_en, hl_row, ram_dout, font_dout, pix_ready,
    input  ram_ce, ram_addr, font_ce, font_addr, pix_valid, pix_data, pix_last,
           busy, done
  );

  // Reader side.
  modport slave (
    input  start, line, abort, hl_en, hl_row, ram_dout, font_dout, pix_ready,
    output ram_ce, ram_addr, font_ce, font_addr, pix_valid, pix_data, pix_last,
           busy, done
  );
endinterface

// File: rtl/menu_text_reader.sv
// Renders one pixel line of a character-mapped menu: per column it fetches the
// character code, then the glyph row, and hands out one 8-pixel byte.
module menu_text_reader #(
  parameter int unsigned COLS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  menu_text_reader_if.slave    bus
);

  localparam int unsigned COL_W  = 5;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned GROW_W = 3;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PIX_W  = 8;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TXT  = 3'd1;
  localparam logic [2:0] S_FNT  = 3'd2;
  localparam logic [2:0] S_LAT  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]        state,     state_nxt;
  logic [COL_W-1:0]  col,       col_nxt;
  logic [ROW_W-1:0]  row,       row_nxt;
  logic [GROW_W-1:0] grow,      grow_nxt;
  logic              hl_match,  hl_match_nxt;
  logic              pix_valid, pix_valid_nxt;
  logic [PIX_W-1:0]  pix_data,  pix_data_nxt;
  logic              pix_last,  pix_last_nxt;
  logic              done,      done_nxt;
  logic              busy,      busy_nxt;
  logic              ram_ce,    ram_ce_nxt;
  logic [ADDR_W-1:0] ram_addr,  ram_addr_nxt;
  logic              font_ce,   font_ce_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      grow      <= '0;
      hl_match  <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ram_ce    <= 1'b0;
      ram_addr  <= '0;
      font_ce   <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      grow      <= grow_nxt;
      hl_match  <= hl_match_nxt;
      pix_valid <= pix_valid_nxt;
      pix_data  <= pix_data_nxt;
      pix_last  <= pix_last_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      ram_ce    <= ram_ce_nxt;
      ram_addr  <= ram_addr_nxt;
      font_ce   <= font_ce_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    grow_nxt      = grow;
    hl_match_nxt  = hl_match;
    pix_valid_nxt = pix_valid;
    pix_data_nxt  = pix_data;
    pix_last_nxt  = pix_last;
    done_nxt      = 1'b0;
    busy_nxt      = 1'b0;
    ram_ce_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    font_ce_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          row_nxt      = bus.line[7:3];
          grow_nxt     = bus.line[2:0];
          hl_match_nxt = bus.hl_en && (bus.hl_row == bus.line[7:3]);
          col_nxt      = '0;
          state_nxt    = S_TXT;
        end
      end
      S_TXT: state_nxt = S_FNT;
      S_FNT: state_nxt = S_LAT;
      S_LAT: begin
        pix_data_nxt  = bus.font_dout ^ {PIX_W{hl_match}};
        pix_valid_nxt = 1'b1;
        pix_last_nxt  = (col == LAST_COL);
        state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (pix_valid && bus.pix_ready) begin
          pix_valid_nxt = 1'b0;
          pix_last_nxt  = 1'b0;
          if (col == LAST_COL) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            col_nxt   = col + COL_W'(1);
            state_nxt = S_TXT;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Cancel wins over everything else, including a handshake on the last byte.
    if (bus.abort && (state != S_IDLE)) begin
      state_nxt     = S_IDLE;
      pix_valid_nxt = 1'b0;
      pix_last_nxt  = 1'b0;
      done_nxt      = 1'b0;
    end

    // Strobes are registered so they are high for exactly the state they belong to.
    busy_nxt    = (state_nxt != S_IDLE);
    ram_ce_nxt  = (state_nxt == S_TXT);
    font_ce_nxt = (state_nxt == S_FNT);
    if (state_nxt == S_TXT) ram_addr_nxt = {row_nxt, col_nxt};
  end

  // The character code only arrives during FNT, so the font address follows it directly.
  assign bus.font_addr = font_ce ? {bus.ram_dout, grow} : '0;

  assign bus.ram_ce    = ram_ce;
  assign bus.ram_addr  = ram_addr;
  assign bus.font_ce   = font_ce;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = pix_data;
  assign bus.pix_last  = pix_last;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_menu_text_reader.sv
// Self-checking bench for menu_text_reader: directed table, corner sequences and
// randomized lines checked against a per-character rendering model.
module tb_menu_text_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] line = 8'h00;
  logic       abort = 1'b0;
  logic       hl_en = 1'b0;
  logic [4:0] hl_row = 5'd0;
  logic       pix_ready = 1'b0;
  logic       sel = 1'b0;      // 0: COLS=32 instance, 1: COLS=1 instance

  menu_text_reader_if b32 ();
  menu_text_reader_if b1 ();

  menu_text_reader #(.COLS(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
  menu_text_reader #(.COLS(1))  u1  (.clk(clk), .reset(reset), .bus(b1.slave));

  assign b32.start = start && !sel;
  assign b1.start  = start && sel;
  assign b32.abort = abort && !sel;
  assign b1.abort  = abort && sel;
  assign b32.line = line;
  assign b1.line  = line;
  assign b32.hl_en = hl_en;
  assign b1.hl_en  = hl_en;
  assign b32.hl_row = hl_row;
  assign b1.hl_row  = hl_row;
  assign b32.pix_ready = pix_ready;
  assign b1.pix_ready  = pix_ready;

  logic [6:0] ram_mem  [1024];
  logic [7:0] font_mem [1024];

  // Synchronous text RAM and font ROM, one per instance.
  always @(posedge clk) begin
    if (b32.ram_ce)  b32.ram_dout  <= ram_mem[b32.ram_addr];
    if (b32.font_ce) b32.font_dout <= font_mem[b32.font_addr];
    if (b1.ram_ce)   b1.ram_dout   <= ram_mem[b1.ram_addr];
    if (b1.font_ce)  b1.font_dout  <= font_mem[b1.font_addr];
  end

  logic       m_valid, m_ready, m_last, m_ram_ce, m_font_ce, m_done, m_busy;
  logic [7:0] m_data;
  logic [9:0] m_ram_addr, m_font_addr;
  always_comb begin
    m_ready = pix_ready;
    if (sel) begin
      m_valid = b1.pix_valid;  m_last = b1.pix_last;  m_data = b1.pix_data;
      m_ram_ce = b1.ram_ce;    m_font_ce = b1.font_ce; m_done = b1.done;
      m_busy = b1.busy;        m_ram_addr = b1.ram_addr; m_font_addr = b1.font_addr;
    end else begin
      m_valid = b32.pix_valid; m_last = b32.pix_last; m_data = b32.pix_data;
      m_ram_ce = b32.ram_ce;   m_font_ce = b32.font_ce; m_done = b32.done;
      m_busy = b32.busy;       m_ram_addr = b32.ram_addr; m_font_addr = b32.font_addr;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_done = 0;
  int         n_font = 0;
  int         done_cyc = 0;
  logic [7:0] cap_data [$];
  logic       cap_last [$];
  logic [9:0] cap_addr [$];
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       hold_last = 1'b0;

  // Observes the selected instance away from the active edge.
  always @(negedge clk) begin
    if (hold && m_valid) begin
      chk("stall_data", 32'(m_data), 32'(hold_data));
      chk("stall_last", 32'(m_last), 32'(hold_last));
    end
    hold      = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    if (m_valid && m_ready) begin
      cap_data.push_back(m_data);
      cap_last.push_back(m_last);
    end
    if (m_ram_ce)  cap_addr.push_back(m_ram_addr);
    if (m_font_ce) n_font++;
    if (m_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // Sink: 0 always ready, 1 random, 2 never ready, 3 ten-cycle stall on the fifth byte.
  int ready_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ($urandom_range(0, 3) != 0);
      2: pix_ready = 1'b0;
      default: begin
        if (cap_data.size() == 4 && m_valid && stall_cnt < 10) begin
          pix_ready = 1'b0;
          stall_cnt++;
        end else begin
          pix_ready = 1'b1;
        end
      end
    endcase
    if (ready_mode != 3) stall_cnt = 0;
  end

  task automatic clear_obs();
    cap_data.delete();
    cap_last.delete();
    cap_addr.delete();
    n_done = 0;
    n_font = 0;
  endtask

  // Issues one line and compares everything observed with the rendering model.
  task automatic run_line(input logic s, input logic [7:0] ln, input logic he,
                          input logic [4:0] hr, input logic spam, input int rmode,
                          input string tag);
    int         cols;
    int         sc;
    logic       inv;
    logic [4:0] r;
    logic [6:0] ch;
    logic [7:0] exp_b;
    cols = s ? 1 : 32;
    @(posedge clk); #1;
    sel = s;
    ready_mode = rmode;
    clear_obs();
    start = 1'b1; line = ln; hl_en = he; hl_row = hr;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0; line = ~ln; hl_en = ~he; hl_row = ~hr;
    for (int k = 0; k < 4000 && m_busy; k++) begin
      start = spam && (k % 3 == 0) && (cap_data.size() < cols - 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("%s_idle", tag), 32'(m_busy), 32'd0);
    inv = he && (hr == ln[7:3]);
    r = ln[7:3];
    chk($sformatf("%s_bytes", tag), 32'(cap_data.size()), 32'(cols));
    chk($sformatf("%s_ramreads", tag), 32'(cap_addr.size()), 32'(cols));
    chk($sformatf("%s_fontreads", tag), 32'(n_font), 32'(cols));
    chk($sformatf("%s_done", tag), 32'(n_done), 32'd1);
    for (int c = 0; c < cols && c < cap_data.size(); c++) begin
      ch = ram_mem[{r, 5'(c)}];
      exp_b = font_mem[{ch, ln[2:0]}] ^ {8{inv}};
      chk($sformatf("%s_data%0d", tag, c), 32'(cap_data[c]), 32'(exp_b));
      chk($sformatf("%s_last%0d", tag, c), 32'(cap_last[c]), 32'(c == cols - 1));
    end
    for (int c = 0; c < cols && c < cap_addr.size(); c++)
      chk($sformatf("%s_addr%0d", tag, c), 32'(cap_addr[c]), 32'({r, 5'(c)}));
    if (rmode == 0)
      chk($sformatf("%s_latency", tag), 32'(done_cyc - sc), 32'(4 * cols + 1));
  endtask

  typedef struct {
    logic [7:0] line;
    logic       hl_en;
    logic [4:0] hl_row;
    logic       sel;
    logic       spam;
    int         rmode;
    logic [7:0] exp_first;
    logic [9:0] exp_addr;
  } vec_t;

  vec_t vt [9];

  initial begin
    bit         found;
    logic [7:0] rl;
    logic [4:0] rr;

    vt[0] = '{8'h1A, 1'b0, 5'd0,  1'b0, 1'b0, 0, 8'h02, 10'd96};
    vt[1] = '{8'h1F, 1'b1, 5'd3,  1'b0, 1'b0, 0, 8'hF8, 10'd96};
    vt[2] = '{8'h20, 1'b1, 5'd3,  1'b0, 1'b0, 0, 8'h00, 10'd128};
    vt[3] = '{8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 0, 8'h00, 10'd0};
    vt[4] = '{8'hFF, 1'b1, 5'd31, 1'b0, 1'b0, 0, 8'hF8, 10'd992};
    vt[5] = '{8'hFF, 1'b0, 5'd0,  1'b1, 1'b0, 0, 8'h07, 10'd992};
    vt[6] = '{8'h5D, 1'b1, 5'd11, 1'b0, 1'b0, 0, 8'hFA, 10'd352};
    vt[7] = '{8'h1A, 1'b0, 5'd3,  1'b0, 1'b0, 3, 8'h02, 10'd96};
    vt[8] = '{8'h1A, 1'b0, 5'd0,  1'b0, 1'b1, 0, 8'h02, 10'd96};

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]  = 7'(i);
      font_mem[i] = 8'(i);
    end

    // Reset state, both instances.
    #3;
    chk("rst_busy", 32'({b32.busy, b1.busy}), 32'd0);
    chk("rst_valid", 32'({b32.pix_valid, b1.pix_valid, b32.pix_last, b1.pix_last}), 32'd0);
    chk("rst_data", 32'({b32.pix_data, b1.pix_data}), 32'd0);
    chk("rst_strobes", 32'({b32.ram_ce, b32.font_ce, b32.done, b1.ram_ce, b1.font_ce, b1.done}), 32'd0);
    chk("rst_addr", 32'({b32.ram_addr, b32.font_addr}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_line(vt[i].sel, vt[i].line, vt[i].hl_en, vt[i].hl_row, vt[i].spam,
               vt[i].rmode, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_first", i), 32'(cap_data.size() > 0 ? cap_data[0] : 8'hxx),
          32'(vt[i].exp_first));
      chk($sformatf("vec%0d_firstaddr", i), 32'(cap_addr.size() > 0 ? cap_addr[0] : 10'hxxx),
          32'(vt[i].exp_addr));
    end

    // Abort while fetching the glyph of the tenth byte.
    @(posedge clk); #1;
    sel = 1'b0; ready_mode = 0; clear_obs();
    start = 1'b1; line = 8'h1A; hl_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (cap_data.size() == 9 && m_font_ce) found = 1'b1;
    end
    chk("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", 32'({m_busy, m_valid, m_ram_ce, m_font_ce}), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(n_done), 32'd0);
    chk("abort_bytes", 32'(cap_data.size()), 32'd9);
    run_line(1'b0, 8'h1A, 1'b0, 5'd0, 1'b0, 0, "after_abort");

    // Start together with abort in IDLE does nothing.
    @(posedge clk); #1;
    clear_obs();
    start = 1'b1; abort = 1'b1; line = 8'h33;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(m_busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("startabort_reads", 32'(cap_addr.size()), 32'd0);

    // Asynchronous reset while a byte waits in OUT.
    clear_obs();
    ready_mode = 2;
    start = 1'b1; line = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (m_valid) found = 1'b1;
    end
    chk("rstmid_reach", 32'(found), 32'd1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rstmid_flags", 32'({b32.busy, b32.pix_valid, b32.pix_last, b32.done}), 32'd0);
    chk("rstmid_data", 32'(b32.pix_data), 32'd0);
    chk("rstmid_ce", 32'({b32.ram_ce, b32.font_ce}), 32'd0);
    chk("rstmid_addr", 32'({b32.ram_addr, b32.font_addr}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_nodone", 32'(n_done), 32'd0);
    run_line(1'b0, 8'h1A, 1'b0, 5'd0, 1'b0, 0, "after_reset");

    // Randomized contents, lines, highlight and sink behaviour.
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]  = 7'($urandom);
      font_mem[i] = 8'($urandom);
    end
    for (int n = 0; n < 16; n++) begin
      rl = 8'($urandom);
      rr = ($urandom_range(0, 1) == 1) ? rl[7:3] : 5'($urandom);
      run_line(($urandom_range(0, 3) == 0), rl, 1'($urandom), rr, 1'($urandom),
               int'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
